pc_source_ctrl: RTL and testbench

- Sequencer that drives the 3-bit select of the PC-source multiplexer, the PC write enable, and the EPC write enable in the multicycle CPU.
- Resolves simultaneous next-PC requests from the control unit by fixed priority.
- Runs the exception sequence: save EPC, read the handler vector byte from memory at a fixed address, then load it into PC.
- Sits between the main control FSM, the memory, and the PC/EPC registers.

---
 rtl/pc_source_ctrl_if.sv | 32 +++
 rtl/pc_source_ctrl.sv | 150 +++++++++++++++
 tb/tb_pc_source_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_source_ctrl_if.sv
// Request/control bundle between the main control FSM and the PC-source sequencer.
// The master side raises next-PC requests and exceptions; the slave side drives the PC/EPC controls.
interface pc_source_ctrl_if;
  logic        inc_req;
  logic        branch_req;
  logic        branch_taken;
  logic        jump_req;
  logic        jr_req;
  logic        rte_req;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [2:0]  pc_source;
  logic        pc_write;
  logic        epc_write;
  logic        mem_read;
  logic [31:0] exc_addr;
  logic [1:0]  cause;
  logic        busy;

  modport master (
    output inc_req, branch_req, branch_taken, jump_req, jr_req, rte_req,
           exc_opcode, exc_ovf, exc_div0,
    input  pc_source, pc_write, epc_write, mem_read, exc_addr, cause, busy
  );

  modport slave (
    input  inc_req, branch_req, branch_taken, jump_req, jr_req, rte_req,
           exc_opcode, exc_ovf, exc_div0,
    output pc_source, pc_write, epc_write, mem_read, exc_addr, cause, busy
  );
endinterface

// File: rtl/pc_source_ctrl.sv
// PC-source sequencer: fixed-priority next-PC arbitration in IDLE, plus the
// exception sequence save EPC -> fetch vector byte -> load PC. All outputs registered.
module pc_source_ctrl #(
  parameter int          MEM_LAT    = 2,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input logic          clk,
  input logic          reset,
  pc_source_ctrl_if.slave bus
);

  localparam int LAT   = (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  localparam logic [2:0] PS_INC    = 3'd0;
  localparam logic [2:0] PS_BRANCH = 3'd1;
  localparam logic [2:0] PS_JUMP   = 3'd2;
  localparam logic [2:0] PS_REG_A  = 3'd3;
  localparam logic [2:0] PS_EPC    = 3'd4;
  localparam logic [2:0] PS_VECTOR = 3'd5;

  typedef enum logic [1:0] {IDLE, EXC_SAVE, EXC_READ, EXC_LOAD} state_t;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_OPCODE, CAUSE_OVF, CAUSE_DIV0} cause_t;

  state_t           state_q, state_n;
  cause_t           cause_q, cause_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       ps_q, ps_n;
  logic             pw_q, pw_n;
  logic             ew_q, ew_n;
  logic             mr_q, mr_n;
  logic [31:0]      addr_q, addr_n;
  logic             busy_q, busy_n;

  function automatic logic [31:0] vec_for(input cause_t c);
    case (c)
      CAUSE_OPCODE: vec_for = VEC_OPCODE;
      CAUSE_OVF:    vec_for = VEC_OVF;
      CAUSE_DIV0:   vec_for = VEC_DIV0;
      default:      vec_for = 32'd0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_n = state_q;
    cause_n = cause_q;
    cnt_n   = cnt_q;
    ps_n    = ps_q;
    pw_n    = 1'b0;
    ew_n    = 1'b0;
    mr_n    = 1'b0;
    addr_n  = 32'd0;
    busy_n  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.exc_opcode || bus.exc_ovf || bus.exc_div0) begin
          if (bus.exc_opcode)   cause_n = CAUSE_OPCODE;
          else if (bus.exc_ovf) cause_n = CAUSE_OVF;
          else                  cause_n = CAUSE_DIV0;
          state_n = EXC_SAVE;
          ew_n    = 1'b1;
          busy_n  = 1'b1;
        end else if (bus.rte_req) begin
          pw_n = 1'b1;
          ps_n = PS_EPC;
        end else if (bus.jr_req) begin
          pw_n = 1'b1;
          ps_n = PS_REG_A;
        end else if (bus.jump_req) begin
          pw_n = 1'b1;
          ps_n = PS_JUMP;
        end else if (bus.branch_req) begin
          // An untaken branch still wins arbitration; the inc request is dropped.
          if (bus.branch_taken) begin
            pw_n = 1'b1;
            ps_n = PS_BRANCH;
          end
        end else if (bus.inc_req) begin
          pw_n = 1'b1;
          ps_n = PS_INC;
        end
      end

      EXC_SAVE: begin
        state_n = EXC_READ;
        cnt_n   = CNT_LOAD;
        mr_n    = 1'b1;
        addr_n  = vec_for(cause_q);
        busy_n  = 1'b1;
      end

      EXC_READ: begin
        busy_n = 1'b1;
        if (cnt_q == '0) begin
          state_n = EXC_LOAD;
          pw_n    = 1'b1;
          ps_n    = PS_VECTOR;
        end else begin
          cnt_n  = cnt_q - 1'b1;
          mr_n   = 1'b1;
          addr_n = vec_for(cause_q);
        end
      end

      EXC_LOAD: state_n = IDLE;

      default:  state_n = IDLE;
    endcase
  end

  // NOTE: every register, including the sticky cause, is cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
      ps_q    <= PS_INC;
      pw_q    <= 1'b0;
      ew_q    <= 1'b0;
      mr_q    <= 1'b0;
      addr_q  <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_n;
      cause_q <= cause_n;
      cnt_q   <= cnt_n;
      ps_q    <= ps_n;
      pw_q    <= pw_n;
      ew_q    <= ew_n;
      mr_q    <= mr_n;
      addr_q  <= addr_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.pc_source = ps_q;
  assign bus.pc_write  = pw_q;
  assign bus.epc_write = ew_q;
  assign bus.mem_read  = mr_q;
  assign bus.exc_addr  = addr_q;
  assign bus.cause     = logic'(cause_q[1]) ? {1'b1, cause_q[0]} : {1'b0, cause_q[0]};
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed bench for pc_source_ctrl: per-cycle expectations are queued when a
// request is driven and compared one cycle later against the registered outputs.
module tb_pc_source_ctrl;

  logic clk;
  logic reset;

  pc_source_ctrl_if bus();

  pc_source_ctrl #(.MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ps;
    logic        pw;
    logic        ew;
    logic        mr;
    logic [31:0] addr;
    logic [1:0]  cause;
    logic        busy;
  } obs_t;

  localparam logic [8:0] R_NONE = 9'h000;
  localparam logic [8:0] R_INC  = 9'h001;
  localparam logic [8:0] R_BR   = 9'h002;
  localparam logic [8:0] R_TK   = 9'h004;
  localparam logic [8:0] R_JMP  = 9'h008;
  localparam logic [8:0] R_JR   = 9'h010;
  localparam logic [8:0] R_RTE  = 9'h020;
  localparam logic [8:0] R_EOP  = 9'h040;
  localparam logic [8:0] R_EOVF = 9'h080;
  localparam logic [8:0] R_EDIV = 9'h100;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic obs_t mk(input logic [2:0] ps, input logic pw, input logic ew,
                              input logic mr, input logic [31:0] addr,
                              input logic [1:0] cause, input logic busy);
    obs_t o;
    o.ps = ps; o.pw = pw; o.ew = ew; o.mr = mr;
    o.addr = addr; o.cause = cause; o.busy = busy;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.ps = bus.pc_source; o.pw = bus.pc_write; o.ew = bus.epc_write;
    o.mr = bus.mem_read; o.addr = bus.exc_addr; o.cause = bus.cause;
    o.busy = bus.busy;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t observed, input obs_t expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed ps=%0d pw=%0b ew=%0b mr=%0b addr=%0d cause=%0d busy=%0b, expected ps=%0d pw=%0b ew=%0b mr=%0b addr=%0d cause=%0d busy=%0b",
             tag, observed.ps, observed.pw, observed.ew, observed.mr, observed.addr,
             observed.cause, observed.busy, expected.ps, expected.pw, expected.ew,
             expected.mr, expected.addr, expected.cause, expected.busy);
    end
  endtask

  task automatic check_invariants(input string tag);
    obs_t o;
    o = observe();
    vectors++;
    assert (!(o.pw && o.ew) && (o.ps < 3'd6)) else begin
      miscompares++;
      $error("FAIL %s invariant: observed pw=%0b ew=%0b ps=%0d, expected not both writes and ps<6",
             tag, o.pw, o.ew, o.ps);
    end
  endtask

  task automatic drive(input logic [8:0] r);
    bus.inc_req      = r[0];
    bus.branch_req   = r[1];
    bus.branch_taken = r[2];
    bus.jump_req     = r[3];
    bus.jr_req       = r[4];
    bus.rte_req      = r[5];
    bus.exc_opcode   = r[6];
    bus.exc_ovf      = r[7];
    bus.exc_div0     = r[8];
  endtask

  task automatic pop_check(input string tag);
    obs_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard, expected a queued entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, observe(), e);
    end
  endtask

  // Drive one request cycle; its result is due one cycle later.
  task automatic step(input string tag, input logic [8:0] r, input obs_t e);
    drive(r);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
    check_invariants(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(R_NONE);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    pop_check("reset_held");
    @(negedge clk);
    reset = 1'b1;

    step("idle_after_reset", R_NONE,        mk(0, 0, 0, 0, 0, 0, 0));
    step("jump_over_inc",    R_INC | R_JMP, mk(2, 1, 0, 0, 0, 0, 0));
    step("pc_write_pulse",   R_NONE,        mk(2, 0, 0, 0, 0, 0, 0));
    step("branch_untaken",   R_BR | R_INC,  mk(2, 0, 0, 0, 0, 0, 0));
    step("branch_taken",     R_BR | R_TK | R_INC, mk(1, 1, 0, 0, 0, 0, 0));
    step("inc_only",         R_INC,         mk(0, 1, 0, 0, 0, 0, 0));
    step("rte_over_jr",      R_RTE | R_JR,  mk(4, 1, 0, 0, 0, 0, 0));
    step("jr_over_jump",     R_JR | R_JMP,  mk(3, 1, 0, 0, 0, 0, 0));

    step("ovf_save",         R_EOVF,        mk(3, 0, 1, 0, 0,   2, 1));
    step("ovf_read0",        R_NONE,        mk(3, 0, 0, 1, 254, 2, 1));
    step("ovf_read1",        R_NONE,        mk(3, 0, 0, 1, 254, 2, 1));
    step("ovf_load",         R_NONE,        mk(5, 1, 0, 0, 0,   2, 1));
    step("ovf_done",         R_NONE,        mk(5, 0, 0, 0, 0,   2, 0));
    step("rte_keeps_cause",  R_RTE,         mk(4, 1, 0, 0, 0,   2, 0));

    step("opc_save",         R_EOP | R_EDIV, mk(4, 0, 1, 0, 0,   1, 1));
    step("opc_read0_jump",   R_JMP,          mk(4, 0, 0, 1, 253, 1, 1));
    step("opc_read1_jump",   R_JMP,          mk(4, 0, 0, 1, 253, 1, 1));
    step("opc_load_jump",    R_JMP,          mk(5, 1, 0, 0, 0,   1, 1));
    step("opc_done",         R_NONE,         mk(5, 0, 0, 0, 0,   1, 0));

    step("div0_save",        R_EDIV,        mk(5, 0, 1, 0, 0,   3, 1));
    step("div0_read0",       R_NONE,        mk(5, 0, 0, 1, 255, 3, 1));

    // Reset lands in the middle of EXC_READ and must clear outputs without a clock edge.
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    pop_check("async_reset_mid_read");
    @(negedge clk);
    reset = 1'b1;

    step("post_reset_idle0", R_NONE,        mk(0, 0, 0, 0, 0, 0, 0));
    step("post_reset_idle1", R_NONE,        mk(0, 0, 0, 0, 0, 0, 0));
    step("post_reset_idle2", R_NONE,        mk(0, 0, 0, 0, 0, 0, 0));
    step("post_reset_jump",  R_JMP,         mk(2, 1, 0, 0, 0, 0, 0));
    step("post_reset_inc",   R_INC,         mk(0, 1, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
